// File: rtl/fifo_rd_drain_if.sv
// FIFO read port plus output stream bundle for fifo_rd_drain.
// master = the drain block, slave = the FIFO/stream neighbours around it.
interface fifo_rd_drain_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic             empty;
  logic             ren;
  logic [WIDTH-1:0] rdata;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready;
  logic             busy;
  logic [15:0]      rd_count;

  modport master (
    input  en, empty, rdata, m_ready,
    output ren, m_valid, m_data, busy, rd_count
  );

  modport slave (
    output en, empty, rdata, m_ready,
    input  ren, m_valid, m_data, busy, rd_count
  );
endinterface

// File: rtl/fifo_rd_drain.sv
// Drains a synchronous FIFO into a valid/ready stream through a 2-entry skid buffer.
// Optional delivered-word counter enabled by defining RD_COUNT_EN.
module fifo_rd_drain #(
  parameter int unsigned WIDTH = 8
) (
  input logic             rclk,
  input logic             rst,
  fifo_rd_drain_if.master bus
);

  localparam int unsigned CNT_W = 2;
  localparam int unsigned OCC_W = 3;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             infl;
  logic             armed;
  logic [WIDTH-1:0] buf0;
  logic [WIDTH-1:0] buf1;
  logic [WIDTH-1:0] buf0_nxt;
  logic [WIDTH-1:0] buf1_nxt;
  logic             pop_c;
  logic             ren_c;
  logic [OCC_W-1:0] occ_c;

  // Occupancy after this edge, read issue and buffer update (buf0 is always the oldest word)
  always_comb begin
    pop_c    = (cnt != CNT_W'(0)) && bus.m_ready;
    occ_c    = OCC_W'(cnt) + OCC_W'(infl) - OCC_W'(pop_c);
    ren_c    = armed && bus.en && !bus.empty && (occ_c < OCC_W'(2));
    cnt_nxt  = occ_c[CNT_W-1:0];
    buf0_nxt = buf0;
    buf1_nxt = buf1;
    case ({infl, pop_c})
      2'b10: begin
        if (cnt == CNT_W'(0)) buf0_nxt = bus.rdata;
        else                  buf1_nxt = bus.rdata;
      end
      2'b01: begin
        buf0_nxt = buf1;
      end
      2'b11: begin
        if (cnt == CNT_W'(1)) begin
          buf0_nxt = bus.rdata;
        end else begin
          buf0_nxt = buf1;
          buf1_nxt = bus.rdata;
        end
      end
      default: begin
      end
    endcase
  end

  // armed holds off the first read until one edge after reset release
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      infl  <= 1'b0;
      armed <= 1'b0;
      buf0  <= '0;
      buf1  <= '0;
    end else begin
      cnt   <= cnt_nxt;
      infl  <= ren_c;
      armed <= 1'b1;
      buf0  <= buf0_nxt;
      buf1  <= buf1_nxt;
    end
  end

  assign bus.ren     = ren_c;
  assign bus.m_valid = (cnt != CNT_W'(0));
  assign bus.m_data  = buf0;
  assign bus.busy    = (cnt != CNT_W'(0)) || infl;

`ifdef RD_COUNT_EN
  logic [15:0] rd_count_q;

  // Free-running delivered-word count, wraps naturally at 16 bits
  always_ff @(posedge rclk or posedge rst) begin
    if (rst)        rd_count_q <= '0;
    else if (pop_c) rd_count_q <= rd_count_q + 16'd1;
  end

  assign bus.rd_count = rd_count_q;
`else
  assign bus.rd_count = 16'd0;
`endif

endmodule

// File: doc/fifo_rd_drain.md
FIFO_RD_DRAIN -- requirements
Module: fifo_rd_drain

Interface
REQ-001 Parameter WIDTH, default 8, data width of rdata and m_data in bits.
REQ-002 rclk  input  1  read-domain clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 en  input  1  drain enable; when low, no new FIFO reads are issued.
REQ-005 empty  input  1  FIFO empty flag, synchronous to rclk.
REQ-006 ren  output  1  FIFO read enable.
REQ-007 rdata  input  WIDTH  FIFO read data, valid in the cycle after ren is high.
REQ-008 m_valid  output  1  output stream word valid.
REQ-009 m_data  output  WIDTH  output stream word.
REQ-010 m_ready  input  1  downstream accepts m_data when high together with m_valid.
REQ-011 busy  output  1  high when the buffer is non-empty or a read is in flight.
REQ-012 rd_count  output  16  count of words delivered on the output stream (see Configuration).

Function
REQ-013 The block SHALL hold a 2-entry FIFO-ordered output buffer (occupancy cnt, 0..2) and a 1-bit in-flight flag infl.
REQ-014 pop SHALL be defined as m_valid && m_ready.
REQ-015 ren SHALL be combinational: en && !empty && (cnt + infl - pop) < 2.
REQ-016 infl SHALL register ren every cycle.
REQ-017 When infl is high, rdata SHALL be written into the buffer at that rising edge.
REQ-018 Push and pop in the same cycle SHALL leave cnt unchanged and preserve order.
REQ-019 cnt SHALL never exceed 2; a capture SHALL never be dropped.
REQ-020 m_valid SHALL equal (cnt != 0); m_data SHALL be the oldest buffered word.
REQ-021 m_data SHALL hold stable while m_valid is high and m_ready is low.
REQ-022 Latency: ren high in cycle N SHALL produce m_valid high with that word in cycle N+2.
REQ-023 With en=1, empty=0 and m_ready=1 held, the block SHALL sustain one word per cycle.
REQ-024 When en is deasserted, an in-flight read SHALL still be captured and delivered.
REQ-025 When empty rises, ren SHALL fall in the same cycle; buffered words SHALL still drain.
REQ-026 busy SHALL equal (cnt != 0) || infl.

Reset
REQ-027 While rst is high: cnt=0, infl=0, buffer contents 0, m_valid=0, m_data=0, ren=0, busy=0, rd_count=0.
REQ-028 Reset mid-operation SHALL discard buffered and in-flight words without any output handshake.
REQ-029 After rst falls, the first ren SHALL be issued no earlier than the first rising edge after release.

Configuration
REQ-030 Macro RD_COUNT_EN defined: rd_count SHALL increment by 1 on every pop and wrap from 16'hFFFF to 0.
REQ-031 RD_COUNT_EN undefined: rd_count SHALL be tied to 0 and the counter logic SHALL be omitted.

Verification
REQ-032 Reset: rst=1 with empty=0, en=1 -> ren=0, m_valid=0, busy=0, rd_count=0.
REQ-033 Streaming: FIFO holds 8'h11..8'h18, m_ready=1 -> m_data sequence 11..18 on 8 consecutive cycles, first one 2 cycles after the first ren.
REQ-034 Backpressure: m_ready=0 for 5 cycles -> exactly 2 reads issued, cnt=2, m_data=8'h11 held stable; then m_ready=1 -> words delivered in order with none lost.
REQ-035 Empty boundary: FIFO holds 1 word -> a single ren pulse, one m_valid beat, then busy=0.
REQ-036 Mid-stream reset: rst pulse while cnt=2 and infl=1 -> m_valid=0 immediately; no stale word appears after release.
REQ-037 Counter (RD_COUNT_EN defined): preload 16'hFFFE-equivalent traffic, 3 pops -> rd_count reads 16'hFFFF, 0, 1.
